// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared video constants, capture FSM encoding and framebuffer
//               pixel packing. Honours macro RGB2FBUF_RGB565_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } cap_state_t;

    localparam int H_ACTIVE_1080 = 1920;
    localparam int V_ACTIVE_1080 = 1080;
    localparam int H_ACTIVE_720  = 1280;
    localparam int V_ACTIVE_720  = 720;
    localparam int H_ACTIVE_600  = 800;
    localparam int V_ACTIVE_600  = 600;

`ifdef RGB2FBUF_RGB565_EN
    localparam int FB_DATA_W = 16;
`else
    localparam int FB_DATA_W = 24;
`endif

    function automatic int fb_depth(input int h, input int v, input int sf);
        return (h / sf) * (v / sf);
    endfunction

    function automatic logic [FB_DATA_W-1:0] fb_pack(input logic [23:0] rgb);
`ifdef RGB2FBUF_RGB565_EN
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
`else
        return rgb;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_meas.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_meas
// Description : Input registering, de/vsync edge detect, x/y counters and
//               line/frame size comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_meas #(
    parameter int H_ACTIVE         = 1920,
    parameter int V_ACTIVE         = 1080,
    parameter int VSYNC_ACTIVE_LOW = 0,
    parameter int X_W              = 12,
    parameter int Y_W              = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vid_de,
    input  logic           vid_vsync,
    input  logic [23:0]    vid_data,
    output logic           de,
    output logic [23:0]    data,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           vs_edge,
    output logic           size_ok,
    output logic           size_err
);

    localparam logic c_VS_INV = (VSYNC_ACTIVE_LOW != 0);

    logic           r_de;
    logic           r_de_q;
    logic           r_vs;
    logic           r_vs_act_q;
    logic [23:0]    r_data;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    logic w_vs_act;
    logic w_vs_edge;
    logic w_de_fall;
    logic w_line_err;
    logic w_frame_err;

    assign w_vs_act  = r_vs ^ c_VS_INV;
    assign w_vs_edge = w_vs_act & ~r_vs_act_q;
    assign w_de_fall = r_de_q & ~r_de;

    // A vsync edge that cuts into an active line makes that line a length error.
    assign w_line_err  = (w_de_fall && (r_x != X_W'(H_ACTIVE))) || (w_vs_edge && r_de);
    assign w_frame_err = w_vs_edge && (r_y != Y_W'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_de       <= 1'b0;
            r_de_q     <= 1'b0;
            r_vs       <= c_VS_INV;
            r_vs_act_q <= 1'b0;
            r_data     <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            r_de       <= vid_de;
            r_de_q     <= r_de;
            r_vs       <= vid_vsync;
            r_vs_act_q <= w_vs_act;
            r_data     <= vid_data;
            // Counters saturate so runaway lines/frames never wrap into range.
            if (w_vs_edge || w_de_fall)
                r_x <= '0;
            else if (r_de && (r_x != '1))
                r_x <= r_x + 1'b1;
            if (w_vs_edge)
                r_y <= '0;
            else if (w_de_fall && (r_y != '1))
                r_y <= r_y + 1'b1;
        end
    end

    assign de       = r_de;
    assign data     = r_data;
    assign x        = r_x;
    assign y        = r_y;
    assign vs_edge  = w_vs_edge;
    assign size_err = w_line_err | w_frame_err;
    assign size_ok  = w_vs_edge & ~(w_line_err | w_frame_err);

endmodule
`default_nettype wire

// File: rtl/rgb2fbuf_capture.sv
`default_nettype none
// ============================================================================
// Module      : rgb2fbuf_capture
// Description : Video capture into framebuffer BRAM: timing lock, decimation
//               and raster write addressing. Macro RGB2FBUF_RGB565_EN selects
//               16-bit RGB565 framebuffer data instead of RGB888.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2fbuf_capture
    import video_pkg::*;
#(
    parameter int H_ACTIVE         = 1920,
    parameter int V_ACTIVE         = 1080,
    parameter int SCALING_FACTOR   = 4,
    parameter int ADDR_W           = 17,
    parameter int LOCK_FRAMES      = 2,
    parameter int VSYNC_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vid_de,
    input  logic                 vid_hsync,
    input  logic                 vid_vsync,
    input  logic [23:0]          vid_data,
    output logic                 fb_we,
    output logic [ADDR_W-1:0]    fb_addr,
    output logic [FB_DATA_W-1:0] fb_wdata,
    output logic                 locked,
    output logic                 frame_start,
    output logic                 err_size
);

    localparam int c_DEPTH = fb_depth(H_ACTIVE, V_ACTIVE, SCALING_FACTOR);
    localparam int c_X_W   = $clog2(H_ACTIVE + 1) + 1;
    localparam int c_Y_W   = $clog2(V_ACTIVE + 1) + 1;
    localparam int c_M_W   = $clog2(LOCK_FRAMES + 1);

    logic             w_de;
    logic [23:0]      w_data;
    logic [c_X_W-1:0] w_x;
    logic [c_Y_W-1:0] w_y;
    logic             w_vs_edge;
    logic             w_size_ok;
    logic             w_size_err;

    cap_state_t       r_state;
    cap_state_t       w_state_nxt;
    logic [c_M_W-1:0] r_match;
    logic [c_M_W-1:0] w_match_nxt;
    logic             w_err;
    logic             w_wr;
    logic             w_sub_zero;
    logic [ADDR_W-1:0] r_ptr;
    logic             r_full;
    logic             w_unused_hsync;

    assign w_unused_hsync = vid_hsync;

    video_timing_meas #(
        .H_ACTIVE         (H_ACTIVE),
        .V_ACTIVE         (V_ACTIVE),
        .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW),
        .X_W              (c_X_W),
        .Y_W              (c_Y_W)
    ) u_meas (
        .clk       (clk),
        .rst_n     (rst_n),
        .vid_de    (vid_de),
        .vid_vsync (vid_vsync),
        .vid_data  (vid_data),
        .de        (w_de),
        .data      (w_data),
        .x         (w_x),
        .y         (w_y),
        .vs_edge   (w_vs_edge),
        .size_ok   (w_size_ok),
        .size_err  (w_size_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_err       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_nxt = ST_MEASURE;
                    w_match_nxt = '0;
                end
            end
            ST_MEASURE: begin
                if (w_size_err)
                    w_state_nxt = ST_SEARCH;
                else if (w_size_ok) begin
                    if (r_match == c_M_W'(LOCK_FRAMES - 1))
                        w_state_nxt = ST_LOCKED;
                    else
                        w_match_nxt = r_match + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_size_err) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    // Scaling factor is a power of two, so the sub-phase is just the low bits.
    assign w_sub_zero = ((w_x & c_X_W'(SCALING_FACTOR - 1)) == '0) &&
                        ((w_y & c_Y_W'(SCALING_FACTOR - 1)) == '0);

    assign w_wr = (r_state == ST_LOCKED) && w_de && !w_vs_edge && w_sub_zero &&
                  (w_x < c_X_W'(H_ACTIVE)) && (w_y < c_Y_W'(V_ACTIVE)) && !r_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_SEARCH;
            r_match     <= '0;
            r_ptr       <= '0;
            r_full      <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            frame_start <= 1'b0;
            err_size    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match     <= w_match_nxt;
            fb_we       <= w_wr;
            frame_start <= w_vs_edge;
            err_size    <= w_err;
            if (w_wr)
                fb_wdata <= fb_pack(w_data);
            // Raster-order writes make a running pointer equal to the 2-D address.
            if (w_vs_edge) begin
                r_ptr   <= '0;
                r_full  <= 1'b0;
                fb_addr <= '0;
            end else if (w_wr) begin
                fb_addr <= r_ptr;
                if (r_ptr == ADDR_W'(c_DEPTH - 1))
                    r_full <= 1'b1;
                else
                    r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign locked = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_rgb2fbuf_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb2fbuf_capture
// Description : Directed bench for rgb2fbuf_capture on a 64x48 / SF=4 stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2fbuf_capture;
    import video_pkg::*;

    localparam int H     = 64;
    localparam int V     = 48;
    localparam int SF    = 4;
    localparam int AW    = 9;
    localparam int H_TOT = 80;
    localparam int DEPTH = (H / SF) * (V / SF);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 vid_de = 1'b0;
    logic                 vid_hsync = 1'b0;
    logic                 vid_vsync = 1'b0;
    logic [23:0]          vid_data = '0;
    logic                 fb_we;
    logic [AW-1:0]        fb_addr;
    logic [FB_DATA_W-1:0] fb_wdata;
    logic                 locked;
    logic                 frame_start;
    logic                 err_size;

    rgb2fbuf_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SCALING_FACTOR(SF), .ADDR_W(AW),
        .LOCK_FRAMES(2), .VSYNC_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vid_de(vid_de), .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync), .vid_data(vid_data), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .locked(locked),
        .frame_start(frame_start), .err_size(err_size)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Monitor state
    int wr_n = 0, ord_err = 0, last_addr = -1, first_we_cyc = -1;
    int err_n = 0, wr_after_err = 0, fs_n = 0, lk_rise_cyc = -1;
    int err_cyc = -10, lk_after_err = -1;
    logic [31:0] d0 = '0, d17 = '0;
    logic lk_prev = 1'b0;
    int de_cyc = -1, vs_cyc = -1;

    always @(negedge clk) begin
        if (fb_we) begin
            if (int'(fb_addr) != wr_n) ord_err++;
            if (fb_addr == 0)  d0  = 32'(fb_wdata);
            if (fb_addr == 17) d17 = 32'(fb_wdata);
            if (wr_n == 0) first_we_cyc = cyc;
            if (err_n > 0) wr_after_err++;
            last_addr = int'(fb_addr);
            wr_n++;
        end
        if (cyc == err_cyc + 1) lk_after_err = int'(locked);
        if (err_size) begin err_n++; err_cyc = cyc; end
        if (frame_start) fs_n++;
        if (locked && !lk_prev) lk_rise_cyc = cyc;
        lk_prev = locked;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input logic [23:0] rgb);
`ifdef RGB2FBUF_RGB565_EN
        return {16'd0, rgb[23:19], rgb[15:10], rgb[7:3]};
`else
        return {8'd0, rgb};
`endif
    endfunction

    task automatic clr_mon();
        wr_n = 0; ord_err = 0; last_addr = -1; first_we_cyc = -1;
    endtask

    // One frame: vsync on lines 0-1, nact active lines from line 3, one blank line after.
    task automatic drive_frame(input int nact, input int short_line, input int rst_line,
                               input bit special);
        for (int l = 0; l < nact + 4; l++) begin
            for (int p = 0; p < H_TOT; p++) begin
                int ya, xa, len;
                bit act;
                @(posedge clk); #1;
                rst_n = 1'b1;
                act = (l >= 3) && (l < 3 + nact);
                ya  = l - 3;
                xa  = p - 8;
                len = (ya == short_line) ? H - 1 : H;
                vid_vsync = (l < 2);
                vid_hsync = (p >= 74);
                vid_de    = act && (p >= 8) && (p < 8 + len);
                vid_data  = (special && xa == 0 && ya == 0) ? 24'hFF8040
                                                             : {12'(xa), 12'(ya)};
                if (l == 0 && p == 0) vs_cyc = cyc;
                if (act && ya == 0 && xa == 0) de_cyc = cyc;
                if (act && ya == rst_line && xa == 20) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    chk("rst_fb_we", 32'(fb_we), 32'd0);
                    chk("rst_locked", 32'(locked), 32'd0);
                    chk("rst_fstart", 32'(frame_start), 32'd0);
                    chk("rst_err", 32'(err_size), 32'd0);
                    chk("rst_addr", 32'(fb_addr), 32'd0);
                    chk("rst_wdata", 32'(fb_wdata), 32'd0);
                end
            end
        end
        @(posedge clk); #1;
        vid_de = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_fb_we", 32'(fb_we), 32'd0);
        chk("init_locked", 32'(locked), 32'd0);
        chk("init_fstart", 32'(frame_start), 32'd0);
        chk("init_err", 32'(err_size), 32'd0);
        chk("init_addr", 32'(fb_addr), 32'd0);
        chk("init_wdata", 32'(fb_wdata), 32'd0);

        // Lock acquisition: three vsync edges.
        clr_mon(); fs_n = 0; err_n = 0;
        drive_frame(V, -1, -1, 1'b0);
        drive_frame(V, -1, -1, 1'b0);
        chk("pre_lock_locked", 32'(locked), 32'd0);
        chk("pre_lock_writes", 32'(wr_n), 32'd0);
        drive_frame(V, -1, -1, 1'b0);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_rise_lat", 32'(lk_rise_cyc - vs_cyc), 32'd2);
        chk("frame_writes", 32'(wr_n), 32'(DEPTH));
        chk("addr_order", 32'(ord_err), 32'd0);
        chk("last_addr", 32'(last_addr), 32'(DEPTH - 1));
        chk("data_addr17", d17, exp_pix({12'd4, 12'd4}));
        chk("we_latency", 32'(first_we_cyc - de_cyc), 32'd2);
        chk("frame_starts", 32'(fs_n), 32'd3);

        clr_mon();
        drive_frame(V, -1, -1, 1'b0);
        chk("steady_writes", 32'(wr_n), 32'(DEPTH));
        chk("steady_no_err", 32'(err_n), 32'd0);

        // Short line while locked, then relock.
        clr_mon(); err_n = 0; wr_after_err = 0;
        drive_frame(V, 10, -1, 1'b0);
        chk("short_err_cnt", 32'(err_n), 32'd1);
        chk("short_unlock", 32'(lk_after_err), 32'd0);
        drive_frame(V, -1, -1, 1'b0);
        drive_frame(V, -1, -1, 1'b0);
        chk("relock_pending", 32'(locked), 32'd0);
        chk("no_wr_after_err", 32'(wr_after_err), 32'd0);
        clr_mon();
        drive_frame(V, -1, -1, 1'b0);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_writes", 32'(wr_n), 32'(DEPTH));
        chk("relock_order", 32'(ord_err), 32'd0);

        // Reset mid-frame, then full relock.
        drive_frame(V, -1, 20, 1'b0);
        clr_mon();
        drive_frame(V, -1, -1, 1'b0);
        drive_frame(V, -1, -1, 1'b0);
        chk("post_rst_locked", 32'(locked), 32'd0);
        chk("post_rst_writes", 32'(wr_n), 32'd0);
        clr_mon();
        drive_frame(V, -1, -1, 1'b1);
        chk("rst_relock", 32'(locked), 32'd1);
        chk("rst_relock_lat", 32'(lk_rise_cyc - vs_cyc), 32'd2);
        chk("rst_relock_wr", 32'(wr_n), 32'(DEPTH));
        chk("data_addr0", d0, exp_pix(24'hFF8040));

        // Two extra lines: writes cap at depth, error only at the next vsync.
        clr_mon(); err_n = 0;
        drive_frame(V + 2, -1, -1, 1'b0);
        chk("extra_writes", 32'(wr_n), 32'(DEPTH));
        chk("extra_last_addr", 32'(last_addr), 32'(DEPTH - 1));
        chk("extra_no_err_yet", 32'(err_n), 32'd0);
        chk("extra_locked", 32'(locked), 32'd1);
        drive_frame(2, -1, -1, 1'b0);
        chk("extra_err_vs", 32'(err_n), 32'd1);
        chk("extra_unlock", 32'(locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
